// File: rtl/ble_pwr_pkg.sv
// Shared power-mode and sequencer-state encodings for the BLE power sequencer.
// State encodings mirror the mode values so a committed mode maps 1:1 to a steady state.
package ble_pwr_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SHUTDOWN  = 3'd0,
    MODE_DEEPSLEEP = 3'd1,
    MODE_SLEEP     = 3'd2,
    MODE_ACTIVE    = 3'd3,
    MODE_RADIO     = 3'd4
  } mode_t;

  typedef enum logic [2:0] {
    ST_SHUTDOWN  = 3'd0,
    ST_DEEPSLEEP = 3'd1,
    ST_SLEEP     = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_RADIO     = 3'd4,
    ST_XFER      = 3'd5
  } state_t;

  function automatic state_t mode_to_state(input mode_t m);
    case (m)
      MODE_DEEPSLEEP: return ST_DEEPSLEEP;
      MODE_SLEEP:     return ST_SLEEP;
      MODE_ACTIVE:    return ST_ACTIVE;
      MODE_RADIO:     return ST_RADIO;
      default:        return ST_SHUTDOWN;
    endcase
  endfunction

endpackage

// File: rtl/ble_pwr_handshake.sv
// Four-phase req/ack handshake with the power-switch controller.
// done_o/abort_o are single-cycle indications in the cycle ack is seen or the wait expires.
module ble_pwr_handshake
  import ble_pwr_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  mode_t             dest_i,
  input  logic              pwr_ack_i,
  output logic              pwr_req_o,
  output logic [MODE_W-1:0] pwr_target_o,
  output logic              done_o,
  output logic              abort_o
);

  localparam int ACK_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LIM = ACK_W'(ACK_TIMEOUT - 1);

  logic              req_q, req_d;
  logic [MODE_W-1:0] target_q, target_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;

  assign done_o       = req_q && pwr_ack_i;
  assign abort_o      = req_q && !pwr_ack_i && (ack_cnt_q >= ACK_LIM);
  assign pwr_req_o    = req_q;
  assign pwr_target_o = target_q;

  // Request/target/wait-counter next state
  always_comb begin
    req_d     = req_q;
    target_d  = target_q;
    ack_cnt_d = ack_cnt_q;
    if (start_i) begin
      req_d     = 1'b1;
      target_d  = dest_i;
      ack_cnt_d = {ACK_W{1'b0}};
    end else if (done_o || abort_o) begin
      req_d     = 1'b0;
      target_d  = MODE_SHUTDOWN;
      ack_cnt_d = {ACK_W{1'b0}};
    end else if (req_q && (ack_cnt_q != ACK_LIM)) begin
      ack_cnt_d = ack_cnt_q + ACK_W'(1);
    end else begin
      ack_cnt_d = ack_cnt_q;
    end
  end

  // Handshake registers; reset drops the request immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= 1'b0;
      target_q  <= MODE_SHUTDOWN;
      ack_cnt_q <= {ACK_W{1'b0}};
    end else begin
      req_q     <= req_d;
      target_q  <= target_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

endmodule

// File: rtl/ble_power_seq.sv
// BLE SoC power-mode sequencer: mode decisions, idle/dwell timers and committed mode,
// with the actual power-switch exchange delegated to ble_pwr_handshake.
module ble_power_seq
  import ble_pwr_pkg::*;
#(
  parameter int NUM_WAKE      = 4,
  parameter int CNT_W         = 16,
  parameter int SLEEP_TIMEOUT = 1000,
  parameter int DEEP_TIMEOUT  = 50000,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_WAKE-1:0] wakeup_event,
  input  logic [NUM_WAKE-1:0] wake_mask,
  input  logic                radio_request,
  input  logic                radio_idle,
  input  logic                cpu_idle,
  input  logic                shutdown_cmd,
  input  logic                pwr_ack,
  output logic                pwr_req,
  output logic [MODE_W-1:0]   pwr_target,
  output logic [MODE_W-1:0]   power_state,
  output logic                busy,
  output logic [NUM_WAKE-1:0] wake_src,
  output logic                ack_error
);

  localparam logic [CNT_W-1:0] SLEEP_LIM = CNT_W'(SLEEP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEEP_LIM  = CNT_W'(DEEP_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [CNT_W-1:0]    idle_q, idle_d, dwell_q, dwell_d;
  logic                busy_q, busy_d, ack_error_q;
  logic [NUM_WAKE-1:0] wake_src_q, wake_src_d, wake_hit_s;
  logic                go_s, wake_go_s, bad_s, start_s, both_idle_s;
  logic                hs_done_s, hs_abort_s;
  mode_t               dest_s, hs_tgt_s;

  assign wake_hit_s  = wakeup_event & wake_mask;
  assign both_idle_s = cpu_idle && radio_idle;
  assign hs_tgt_s    = mode_t'(pwr_target);

  // Steady-state transition decision, in priority order
  always_comb begin
    go_s      = 1'b0;
    wake_go_s = 1'b0;
    bad_s     = 1'b0;
    dest_s    = MODE_SHUTDOWN;
    case (state_q)
      ST_SHUTDOWN: begin
        if (wakeup_event[0]) begin go_s = 1'b1; dest_s = MODE_ACTIVE; end
        else go_s = 1'b0;
      end
      ST_SLEEP, ST_DEEPSLEEP: begin
        if (shutdown_cmd) begin go_s = 1'b1; dest_s = MODE_SHUTDOWN; end
        else if (|wake_hit_s) begin go_s = 1'b1; wake_go_s = 1'b1; dest_s = MODE_ACTIVE; end
        else if (radio_request) begin go_s = 1'b1; dest_s = MODE_RADIO; end
        else if ((state_q == ST_SLEEP) && (dwell_q >= DEEP_LIM)) begin
          go_s = 1'b1; dest_s = MODE_DEEPSLEEP;
        end else go_s = 1'b0;
      end
      ST_ACTIVE: begin
        if (shutdown_cmd) begin go_s = 1'b1; dest_s = MODE_SHUTDOWN; end
        else if (radio_request) begin go_s = 1'b1; dest_s = MODE_RADIO; end
        else if (both_idle_s && (idle_q >= SLEEP_LIM)) begin go_s = 1'b1; dest_s = MODE_SLEEP; end
        else go_s = 1'b0;
      end
      ST_RADIO: begin
        if (shutdown_cmd) begin go_s = 1'b1; dest_s = MODE_SHUTDOWN; end
        else if (radio_idle && !radio_request) begin go_s = 1'b1; dest_s = MODE_ACTIVE; end
        else go_s = 1'b0;
      end
      ST_XFER: go_s = 1'b0;
      default: bad_s = 1'b1;
    endcase
  end

  // Next state: launch, commit or abort a transfer; counters run only while steady
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    wake_src_d = wake_src_q;
    idle_d     = {CNT_W{1'b0}};
    dwell_d    = {CNT_W{1'b0}};
    start_s    = 1'b0;
    if (bad_s) begin
      state_d = ST_SHUTDOWN;
      mode_d  = MODE_SHUTDOWN;
      busy_d  = 1'b0;
    end else if (state_q == ST_XFER) begin
      if (hs_done_s) begin
        mode_d  = hs_tgt_s;
        state_d = mode_to_state(hs_tgt_s);
        busy_d  = 1'b0;
      end else if (hs_abort_s) begin
        state_d = mode_to_state(mode_q);
        busy_d  = 1'b0;
      end else begin
        state_d = ST_XFER;
      end
    end else if (go_s && !pwr_ack) begin
      start_s = 1'b1;
      state_d = ST_XFER;
      busy_d  = 1'b1;
      if (wake_go_s) wake_src_d = wake_hit_s;
      else wake_src_d = wake_src_q;
    end else begin
      idle_d  = ((state_q == ST_ACTIVE) && both_idle_s) ? sat_inc(idle_q) : {CNT_W{1'b0}};
      dwell_d = (state_q == ST_SLEEP) ? sat_inc(dwell_q) : {CNT_W{1'b0}};
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SHUTDOWN;
      mode_q      <= MODE_SHUTDOWN;
      idle_q      <= {CNT_W{1'b0}};
      dwell_q     <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      wake_src_q  <= {NUM_WAKE{1'b0}};
      ack_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idle_q      <= idle_d;
      dwell_q     <= dwell_d;
      busy_q      <= busy_d;
      wake_src_q  <= wake_src_d;
      ack_error_q <= hs_abort_s;
    end
  end

  ble_pwr_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hs (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_s),
    .dest_i       (dest_s),
    .pwr_ack_i    (pwr_ack),
    .pwr_req_o    (pwr_req),
    .pwr_target_o (pwr_target),
    .done_o       (hs_done_s),
    .abort_o      (hs_abort_s)
  );

  assign power_state = mode_q;
  assign busy        = busy_q;
  assign wake_src    = wake_src_q;
  assign ack_error   = ack_error_q;

endmodule

// File: doc/ble_power_seq.md
Name: ble_power_seq

Overview:
Parametrised successor to power_fsm, the BLE SoC power-mode sequencer.
- Adds a RADIO mode, NUM_WAKE maskable wake sources, and internal idle/dwell timers in place of the external timer_expired.
- Adds a four-phase req/ack handshake with the power-switch controller, with timeout recovery.
- Sits between the wake/event logic and the power-switch controller; drives the committed power mode to clock/reset gating.

Parameters:
NUM_WAKE, 4, number of wake sources; bit 0 is the hard (power-button) wake
CNT_W, 16, width of idle/dwell counters
SLEEP_TIMEOUT, 1000, consecutive idle cycles in ACTIVE before requesting SLEEP (1..2^CNT_W-1)
DEEP_TIMEOUT, 50000, cycles dwelling in SLEEP before requesting DEEPSLEEP (1..2^CNT_W-1)
ACK_TIMEOUT, 64, cycles to wait for pwr_ack before abort (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wakeup_event  in  NUM_WAKE  level wake requests
wake_mask  in  NUM_WAKE  1 = source enabled for SLEEP/DEEPSLEEP exit
radio_request  in  1  radio needs power
radio_idle  in  1  radio quiescent
cpu_idle  in  1  CPU in WFI
shutdown_cmd  in  1  software shutdown request
pwr_ack  in  1  power-switch acknowledge
pwr_req  out  1  power-switch request
pwr_target  out  3  requested mode, valid while pwr_req=1
power_state  out  3  committed mode: SHUTDOWN=0, DEEPSLEEP=1, SLEEP=2, ACTIVE=3, RADIO=4
busy  out  1  transition in progress
wake_src  out  NUM_WAKE  wake bits that caused the last wake transition
ack_error  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (async assert, sync release):
  - state SHUTDOWN; power_state=0, pwr_req=0, pwr_target=0, busy=0, wake_src=0, ack_error=0; counters 0.
  - Reset mid-handshake drops pwr_req immediately.
- Decision rules in steady state, evaluated each cycle, priority high to low:
  - SHUTDOWN: wakeup_event[0] (mask ignored) -> ACTIVE. Nothing else exits SHUTDOWN.
  - Any non-SHUTDOWN state: shutdown_cmd -> SHUTDOWN.
  - SLEEP/DEEPSLEEP: any bit of (wakeup_event & wake_mask) -> ACTIVE. That vector is latched into wake_src on the decision cycle.
  - SLEEP/DEEPSLEEP: radio_request -> RADIO.
  - ACTIVE: radio_request -> RADIO.
  - RADIO: radio_idle && !radio_request -> ACTIVE.
  - ACTIVE idle: idle_cnt counts cycles with cpu_idle && radio_idle, clears on any cycle either is low. The decision to go to SLEEP fires when idle_cnt==SLEEP_TIMEOUT-1 with the condition still true, i.e. on the SLEEP_TIMEOUT-th consecutive idle cycle.
  - SLEEP dwell: dwell_cnt counts every cycle in SLEEP. The decision to go to DEEPSLEEP fires on the DEEP_TIMEOUT-th cycle.
  - Both counters clear on any state change.
- Handshake (XFER):
  - Decision cycle: next edge sets pwr_req=1, pwr_target=dest, busy=1. power_state still shows the source.
  - A new request is never raised while pwr_ack=1; the block waits in steady state until ack is low.
  - pwr_ack sampled high: next edge commits power_state=dest, pwr_req=0, busy=0.
  - ack_cnt counts XFER cycles. If ack is not seen by ACK_TIMEOUT cycles: drop pwr_req, pulse ack_error, return to source with power_state unchanged and busy=0. The decision is re-evaluated afresh from the next cycle.
  - During XFER all inputs except reset are ignored; wake_src is not updated.
  - A shutdown_cmd arriving mid-XFER is acted on after commit/abort only if still asserted.
- Simultaneous events follow the priority list above, e.g. wake + shutdown_cmd in SLEEP -> SHUTDOWN.
- Counters saturate and never wrap.
- Minimum latency from decision to committed power_state = 2 edges, with ack returned the cycle after req.

Decomposition:
- Shared package ble_pwr_pkg:
  - power-mode typedef/localparams: SHUTDOWN, DEEPSLEEP, SLEEP, ACTIVE, RADIO.
  - internal state encoding (adds XFER).
  - mode width constant (3).
- One natural sub-module, ble_pwr_handshake: owns pwr_req/pwr_target/ack_cnt/timeout and returns done/abort. The main FSM holds mode decision and counters.

Test Plan:
Bench parameters: NUM_WAKE=4, SLEEP_TIMEOUT=8, DEEP_TIMEOUT=16, ACK_TIMEOUT=4; responder acks 1 cycle after req, drops ack after req falls.
1. Release reset, pulse wakeup_event=4'b0010 -> stays SHUTDOWN. Pulse 4'b0001 -> pwr_req with pwr_target=3, power_state=3 two edges later.
2. In ACTIVE, hold cpu_idle=radio_idle=1 -> pwr_req rises on the 8th idle edge, SLEEP(2) committed. Dropping cpu_idle at cycle 5 instead -> no transition, count restarts.
3. Remain in SLEEP 16 cycles -> DEEPSLEEP(1). Then wake_mask=4'b0100, wakeup_event=4'b0110 -> ACTIVE, wake_src=4'b0100.
4. ACTIVE, radio_request=1 -> RADIO(4). radio_idle=1 with radio_request=0 -> ACTIVE(3). Simultaneous shutdown_cmd+radio_request in ACTIVE -> SHUTDOWN(0).
5. Responder withholds ack -> pwr_req high exactly 4 cycles, ack_error one-cycle pulse, power_state unchanged, busy=0.
6. Assert reset_n=0 while pwr_req=1 -> pwr_req=0 and power_state=0 asynchronously, before the next clk edge.
